// File: rtl/common_pkg.sv
// Shared data-bus types used by every pipeline stage that talks to memory.
// Holds the request/response bundles and the access-size encoding.
package common_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/memory_stage_pkg.sv
// Pipeline bundles, memory-stage FSM states and access-size decode helpers.
// Optional misalignment trap is keyed by MEMORY_MISALIGN_CHECK_EN in memory_stage.
package memory_stage_pkg;
    import common_pkg::*;

    typedef enum logic [2:0] {
        NOP, ALU, BRANCH, JUMP, LD, SD
    } op_t;

    typedef struct packed {
        op_t  op;
        logic regwrite;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] rd2;
    } excute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] addr;
    } memory_data_t;

    typedef struct packed {
        logic        ismem;
        logic [4:0]  dst;
        logic [63:0] data;
    } tran_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mstate_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic msize_t size_of(input logic [1:0] c);
        unique case (c)
            SZ_B:    return MSIZE1;
            SZ_H:    return MSIZE2;
            SZ_W:    return MSIZE4;
            default: return MSIZE8;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] c);
        unique case (c)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] c);
        unique case (c)
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            SZ_W:    return |a[1:0];
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane steering for the data bus: store strobe/data alignment and
// load extraction with sign or zero extension. Purely combinational.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  addr,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [63:0] wsrc,
    input  logic [63:0] rdata,
    output logic [7:0]  strobe,
    output logic [63:0] wdata,
    output logic [63:0] rvalue
);

    logic [63:0] shifted;

    // Align store lanes and extract/extend the addressed load lanes
    always_comb begin
        strobe  = size_mask(size) << addr;
        wdata   = wsrc << {addr, 3'b000};
        shifted = rdata >> {addr, 3'b000};
        unique case (size)
            SZ_B: rvalue = zext ? {56'd0, shifted[7:0]}
                                : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H: rvalue = zext ? {48'd0, shifted[15:0]}
                                : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W: rvalue = zext ? {32'd0, shifted[31:0]}
                                : {{32{shifted[31]}}, shifted[31:0]};
            default: rvalue = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on the data bus, stalls upstream
// until data_ok, registers the writeback bundle. Option: MEMORY_MISALIGN_CHECK_EN.
module memory_stage
    import common_pkg::*;
    import memory_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output memory_data_t dataM,
    output logic         stallM,
    output tran_t        fwdM
);

    mstate_t      state_q, state_d;
    memory_data_t dataM_q, dataM_d;

    logic [1:0]  size_code;
    logic        is_ld, is_sd, mem_op, bad_align, issue;
    logic [7:0]  st_strobe;
    logic [63:0] st_wdata, ld_value;
    logic        unused_addr_ok;

    assign size_code      = dataE.instr[13:12];
    assign is_ld          = dataE.valid && (dataE.ctl.op == LD);
    assign is_sd          = dataE.valid && (dataE.ctl.op == SD);
    assign mem_op         = is_ld || is_sd;
    assign unused_addr_ok = dresp.addr_ok;

`ifdef MEMORY_MISALIGN_CHECK_EN
    assign bad_align = mem_op && misaligned(dataE.result[2:0], size_code);
`else
    assign bad_align = 1'b0;
`endif

    assign issue  = mem_op && !bad_align;
    assign stallM = issue && !dresp.data_ok;

    mem_align u_align (
        .addr   (dataE.result[2:0]),
        .size   (size_code),
        .zext   (dataE.instr[14]),
        .wsrc   (dataE.rd2),
        .rdata  (dresp.data),
        .strobe (st_strobe),
        .wdata  (st_wdata),
        .rvalue (ld_value)
    );

    // Bus request is driven straight from the held execute bundle
    always_comb begin
        dreq        = '0;
        dreq.valid  = issue;
        dreq.addr   = dataE.result;
        dreq.size   = size_of(size_code);
        dreq.strobe = is_sd ? st_strobe : 8'h00;
        dreq.data   = st_wdata;
    end

    // Forwarding tap for the instruction currently in this stage
    always_comb begin
        fwdM       = '0;
        fwdM.ismem = is_ld;
        fwdM.dst   = (dataE.valid && dataE.ctl.regwrite) ? dataE.dst : 5'd0;
        fwdM.data  = dataE.result;
    end

    // Access tracking: BUSY while a request waits for data_ok
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue && !dresp.data_ok) state_d = BUSY;
            BUSY:    if (!issue || dresp.data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writeback bundle: bubble while stalled, else capture the result
    always_comb begin
        dataM_d = '0;
        if (!stallM) begin
            dataM_d.valid  = dataE.valid;
            dataM_d.pc     = dataE.pc;
            dataM_d.instr  = dataE.instr;
            dataM_d.ctl    = dataE.ctl;
            dataM_d.dst    = dataE.dst;
            dataM_d.result = dataE.result;
            dataM_d.addr   = dataE.result;
            if (bad_align) begin
                dataM_d.ctl.regwrite = 1'b0;
                dataM_d.result       = 64'd0;
            end else if (is_ld) begin
                dataM_d.result = ld_value;
            end
        end
    end

    // State and writeback registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dataM_q <= '0;
        end else begin
            state_q <= state_d;
            dataM_q <= dataM_d;
        end
    end

    assign dataM = dataM_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed pass-through, load, store,
// reset-abort and misalignment vectors with hand-computed expectations.
module tb_memory_stage;
    import common_pkg::*;
    import memory_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    excute_data_t dataE;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;
    memory_data_t dataM;
    logic         stallM;
    tran_t        fwdM;

    int errors = 0;
    int checks = 0;
    memory_data_t exp_q[$];

    always #5 clk = ~clk;

    memory_stage dut (
        .clk    (clk),
        .reset  (reset),
        .dataE  (dataE),
        .dreq   (dreq),
        .dresp  (dresp),
        .dataM  (dataM),
        .stallM (stallM),
        .fwdM   (fwdM)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic excute_data_t mk(input op_t op, input logic rw,
                                        input logic [2:0] f3,
                                        input logic [4:0] dst,
                                        input logic [63:0] res,
                                        input logic [63:0] rd2);
        excute_data_t d;
        d.valid        = 1'b1;
        d.pc           = 64'h8000_0000 | {57'd0, dst, 2'b00};
        d.instr        = {17'd0, f3, 5'd0, 7'h23};
        d.ctl.op       = op;
        d.ctl.regwrite = rw;
        d.dst          = dst;
        d.result       = res;
        d.rd2          = rd2;
        return d;
    endfunction

    function automatic memory_data_t expm(input excute_data_t d,
                                          input logic [63:0] res,
                                          input logic rw);
        memory_data_t m;
        m.valid        = 1'b1;
        m.pc           = d.pc;
        m.instr        = d.instr;
        m.ctl          = d.ctl;
        m.ctl.regwrite = rw;
        m.dst          = d.dst;
        m.result       = res;
        m.addr         = d.result;
        return m;
    endfunction

    // Monitor: every valid writeback bundle must match the queue head
    always @(negedge clk) begin
        memory_data_t e;
        if (!reset && dataM.valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dataM unexpected: got valid result=%h, required none",
                         dataM.result);
            end else begin
                e = exp_q.pop_front();
                if (dataM !== e) begin
                    errors++;
                    $display("FAIL dataM pc=%h: got result=%h rw=%b addr=%h required result=%h rw=%b addr=%h",
                             e.pc, dataM.result, dataM.ctl.regwrite, dataM.addr,
                             e.result, e.ctl.regwrite, e.addr);
                end
            end
        end
    end

    task automatic pass(input string nm, input excute_data_t d,
                        input logic [4:0] fdst);
        dataE = d;
        exp_q.push_back(expm(d, d.result, d.ctl.regwrite));
        @(negedge clk);
        chk({nm, " stallM"}, stallM, 0);
        chk({nm, " dreq.valid"}, dreq.valid, 0);
        chk({nm, " fwd.dst"}, fwdM.dst, fdst);
        chk({nm, " fwd.data"}, fwdM.data, d.result);
        @(posedge clk);
        #1;
        dataE.valid = 1'b0;
    endtask

    task automatic run_mem(input string nm, input excute_data_t d,
                           input int lat, input logic [63:0] rdata,
                           input logic [63:0] res, input msize_t sz,
                           input logic [7:0] strb, input logic [63:0] wd);
        dataE = d;
        dresp = '0;
        exp_q.push_back(expm(d, res, d.ctl.regwrite));
        for (int k = 0; k <= lat; k++) begin
            if (k == lat) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = rdata;
            end else begin
                dresp.addr_ok = (k == 1);
            end
            @(negedge clk);
            chk({nm, " dreq.valid"}, dreq.valid, 1);
            chk({nm, " dreq.addr"}, dreq.addr, d.result);
            chk({nm, " dreq.size"}, 64'(dreq.size), 64'(sz));
            chk({nm, " dreq.strobe"}, dreq.strobe, strb);
            chk({nm, " dreq.data"}, dreq.data, wd);
            chk({nm, " stallM"}, stallM, (k < lat) ? 64'd1 : 64'd0);
            if (k >= 1) chk({nm, " bubble"}, dataM.valid, 0);
            if (k == 0) chk({nm, " fwd.ismem"}, fwdM.ismem, d.ctl.op == LD);
            @(posedge clk);
            #1;
        end
        dataE.valid = 1'b0;
        dresp       = '0;
    endtask

    initial begin
        excute_data_t d;
        reset = 1'b1;
        dataE = '0;
        dresp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset dataM zero", dataM == '0, 1);
        chk("reset stallM", stallM, 0);
        chk("reset dreq.valid", dreq.valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        pass("alu", mk(ALU, 1, 3'b000, 5'd5, 64'h1234, 64'd0), 5'd5);
        pass("alu nowb", mk(ALU, 0, 3'b000, 5'd7,
                            64'hFFFF_0000_0000_0001, 64'd0), 5'd0);

        run_mem("lb", mk(LD, 1, 3'b000, 5'd10, 64'h8000_0003, 64'd0), 3,
                64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80,
                MSIZE1, 8'h00, 64'd0);
        run_mem("sw", mk(SD, 0, 3'b010, 5'd0, 64'h8000_0004,
                         64'h0000_0000_DEAD_BEEF), 2,
                64'd0, 64'h8000_0004, MSIZE4, 8'hF0,
                64'hDEAD_BEEF_0000_0000);
        run_mem("lhu", mk(LD, 1, 3'b101, 5'd11, 64'h8000_0006, 64'd0), 0,
                64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001,
                MSIZE2, 8'h00, 64'd0);
        run_mem("lw", mk(LD, 1, 3'b010, 5'd12, 64'h8000_0000, 64'd0), 1,
                64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001,
                MSIZE4, 8'h00, 64'd0);
        run_mem("sb", mk(SD, 0, 3'b000, 5'd0, 64'h8000_0005, 64'h0AB), 2,
                64'd0, 64'h8000_0005, MSIZE1, 8'h20,
                64'h0000_AB00_0000_0000);
        run_mem("ld", mk(LD, 1, 3'b011, 5'd13, 64'h8000_0008, 64'd0), 1,
                64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788,
                MSIZE8, 8'h00, 64'd0);

`ifdef MEMORY_MISALIGN_CHECK_EN
        d = mk(LD, 1, 3'b011, 5'd14, 64'h8000_0004, 64'd0);
        dataE = d;
        exp_q.push_back(expm(d, 64'd0, 1'b0));
        @(negedge clk);
        chk("mis dreq.valid", dreq.valid, 0);
        chk("mis stallM", stallM, 0);
        @(posedge clk);
        #1;
        dataE.valid = 1'b0;
`else
        run_mem("mis ld", mk(LD, 1, 3'b011, 5'd14, 64'h8000_0004, 64'd0), 1,
                64'hAAAA_BBBB_CCCC_DDDD, 64'h0000_0000_AAAA_BBBB,
                MSIZE8, 8'h00, 64'd0);
`endif

        d = mk(LD, 1, 3'b011, 5'd15, 64'h8000_0010, 64'd0);
        d.valid = 1'b0;
        dataE = d;
        @(negedge clk);
        chk("invalid dreq.valid", dreq.valid, 0);
        chk("invalid stallM", stallM, 0);
        chk("invalid fwd.dst", fwdM.dst, 0);
        @(negedge clk);
        chk("invalid dataM.valid", dataM.valid, 0);
        @(posedge clk);
        #1;

        dataE = mk(LD, 1, 3'b010, 5'd16, 64'h8000_0020, 64'd0);
        dresp = '0;
        repeat (2) begin
            @(negedge clk);
            chk("busy stallM", stallM, 1);
            @(posedge clk);
            #1;
        end
        reset       = 1'b1;
        dataE.valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort dreq.valid", dreq.valid, 0);
        chk("abort dataM.valid", dataM.valid, 0);
        chk("abort dataM zero", dataM == '0, 1);
        chk("abort stallM", stallM, 0);
        @(posedge clk);
        #1;

        pass("alu post", mk(ALU, 1, 3'b000, 5'd3, 64'h0055_AA00, 64'd0), 5'd3);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  stage clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dataE  input  excute_data_t  execute-stage bundle; upstream holds it stable while stallM=1.
REQ-005 dreq  output  dbus_req_t  data-bus request: valid, addr, size, strobe, data.
REQ-006 dresp  input  dbus_resp_t  data-bus response: addr_ok, data_ok, data.
REQ-007 dataM  output  memory_data_t  registered bundle to writeback.
REQ-008 stallM  output  1  freezes fetch/decode/execute while a bus access is pending.
REQ-009 fwdM  output  tran_t  forwarding tap: ismem, dst, data of the instruction currently in this stage.

Function
REQ-010 The stage SHALL treat dataE.valid=1 with ctl.op in {LD, SD} as a memory op and every other valid op as pass-through.
REQ-011 Pass-through: dataM SHALL capture pc/instr/ctl/dst/valid with result=dataE.result and addr=dataE.result at the next edge (1-cycle latency), stallM=0.
REQ-012 FSM states SHALL be IDLE and BUSY; reset state IDLE.
REQ-013 IDLE + memory op: dreq.valid=1 combinationally, stallM=1, next state BUSY unless dresp.data_ok is already 1 that cycle.
REQ-014 BUSY: dreq SHALL stay valid with identical fields until dresp.data_ok=1; that cycle stallM=0, dataM captures at the edge, state returns to IDLE.
REQ-015 While stallM=1, dataM.valid SHALL be written 0 (bubble) at each edge.
REQ-016 Access size from instr[13:12]: 0=byte, 1=half, 2=word, 3=double; dreq.size SHALL be MSIZE1/2/4/8 accordingly; dreq.addr=dataE.result.
REQ-017 Store: dreq.strobe SHALL be the size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0]; dreq.data SHALL be rd2 shifted left by 8*addr[2:0].
REQ-018 Load: the result SHALL be dresp.data shifted right by 8*addr[2:0], truncated to size, zero-extended if instr[14]=1, else sign-extended to 64 bits; strobe=0.
REQ-019 Store dataM.result SHALL be dataE.result; regwrite passes unchanged from ctl.
REQ-020 fwdM.dst SHALL be dataE.dst when dataE.valid and ctl.regwrite, else 0; fwdM.ismem=1 for LD; fwdM.data=dataE.result.
REQ-021 dataE.valid=0 SHALL produce no bus request and dataM.valid=0.
REQ-022 dresp.addr_ok without data_ok SHALL NOT end the access.

Reset
REQ-023 Reset SHALL force state IDLE, dataM to all-zero (valid=0), dreq.valid=0 in the following cycle, and stallM=0; reset mid-access abandons it without writeback.

Configuration
REQ-024 With MEMORY_MISALIGN_CHECK_EN defined, an access whose addr is not a multiple of its size SHALL issue no bus request, complete in one cycle with dataM.valid=1, dataM.ctl.regwrite=0, dataM.result=0.
REQ-025 Without MEMORY_MISALIGN_CHECK_EN, misaligned accesses SHALL be issued unchanged, with shift/strobe per REQ-017/018.

Structure
REQ-026 The FSM state enum and the access-size decode constants SHALL live in the pipes package; bus types stay in common.
REQ-027 Load extraction/extension and store alignment SHALL be one combinational sub-module, mem_align.

Verification
REQ-028 Pass-through ALU op, result=0x1234 -> dataM.result=0x1234 next cycle, stallM never 1.
REQ-029 LD (instr[14:12]=3'b000) addr 0x80000003, data_ok after 3 cycles with data byte3=0x80 -> stallM=1 for 3 cycles, dataM.result=0xFFFF_FFFF_FFFF_FF80.
REQ-030 SD word (funct3=010) addr 0x80000004, rd2=0xDEADBEEF -> strobe=0xF0, dreq.data=0xDEADBEEF_00000000, held until data_ok.
REQ-031 LHU addr 0x80000006, data[63:48]=0x8001 -> result=0x0000_0000_0000_8001.
REQ-032 Reset asserted while BUSY -> next cycle dreq.valid=0, dataM.valid=0, state IDLE.
REQ-033 With MEMORY_MISALIGN_CHECK_EN, LD double at 0x80000004 -> no dreq.valid, dataM.valid=1, regwrite=0.
